// File: rtl/mult_unit_pkg.sv
// Shared definitions for the iterative multiplier and its neighbours.
//   - Multiplier FSM state encoding.
//   - Default operand width and iteration counter width.
//   - Decoder function codes for MULT/MULTU and MFHI/MFLO, shared by the
//     decoder and the hazard unit so both agree on what touches HI/LO.
package mult_unit_pkg;

  localparam int MULT_WIDTH = 32;
  localparam int MULT_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } mult_state_e;

  localparam logic [5:0] FUNC_MFHI  = 6'h10;
  localparam logic [5:0] FUNC_MFLO  = 6'h12;
  localparam logic [5:0] FUNC_MULT  = 6'h18;
  localparam logic [5:0] FUNC_MULTU = 6'h19;

  // True for the R-type functions that start a multiply.
  function automatic logic is_mult_func(input logic [5:0] func);
    return (func == FUNC_MULT) || (func == FUNC_MULTU);
  endfunction

  // True for the R-type functions that read HI/LO and must stall on busy.
  function automatic logic is_mfhilo_func(input logic [5:0] func);
    return (func == FUNC_MFHI) || (func == FUNC_MFLO);
  endfunction

endpackage

// File: rtl/mult_unit_if.sv
// Decoder/hazard-side bundle for the multiplier.
//   master: issuer (decoder + register read) drives start_mult, mult_sign,
//           src_a, src_b and observes busy, done, hi, lo.
//   slave : mult_unit, the reverse.
interface mult_unit_if
  import mult_unit_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
);

  logic             start_mult;
  logic             mult_sign;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start_mult, mult_sign, src_a, src_b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start_mult, mult_sign, src_a, src_b,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/mult_unit_abs.sv
// Conditional two's-complement negate.
//   val_i : input value (W bits)
//   neg_i : 1 = output -val_i, 0 = output val_i
//   val_o : result, wraps modulo 2^W (the most negative value maps to itself,
//           which read as unsigned is its correct magnitude)
module mult_unit_abs #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] val_o
);

  assign val_o = neg_i ? -val_i : val_i;

endmodule

// File: rtl/mult_unit.sv
// Iterative radix-2 multiplier for MULT/MULTU, owner of the HI/LO registers.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus.slave  : start_mult/mult_sign/src_a/src_b in; busy/done/hi/lo out
// Operands are reduced to magnitudes at start, multiplied unsigned over WIDTH
// shift-add steps, and the sign is reapplied in a final FIX cycle. HI/LO only
// change on that FIX edge; busy covers RUN and FIX so hazards stall readers.
module mult_unit
  import mult_unit_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int CNT_W = MULT_CNT_W
) (
  input  logic     clk,
  input  logic     rst_n,
  mult_unit_if.slave bus
);

  if ((1 << CNT_W) <= WIDTH) begin : g_bad_cnt_w
    $error("mult_unit: CNT_W too small to count WIDTH iterations");
  end

  mult_state_e        state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               sign_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               done_q;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] prod;

  mult_unit_abs #(.W(WIDTH)) u_abs_a (
    .val_i (bus.src_a),
    .neg_i (bus.mult_sign & bus.src_a[WIDTH-1]),
    .val_o (a_mag)
  );

  mult_unit_abs #(.W(WIDTH)) u_abs_b (
    .val_i (bus.src_b),
    .neg_i (bus.mult_sign & bus.src_b[WIDTH-1]),
    .val_o (b_mag)
  );

  mult_unit_abs #(.W(2*WIDTH)) u_abs_p (
    .val_i (acc_q),
    .neg_i (sign_q),
    .val_o (prod)
  );

  // One shift-add step: multiplicand is pre-shifted, so add it whenever the
  // current low multiplier bit is set.
  assign acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the datapath registers are reset too, so an aborted multiply
      // leaves no stale operands or partial product behind.
      state_q  <= IDLE;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start_mult) begin
            sign_q   <= bus.mult_sign & (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
            mcand_q  <= {{WIDTH{1'b0}}, a_mag};
            mplier_q <= b_mag;
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          {hi_q, lo_q} <= prod;
          done_q       <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: doc/mult_unit.md
Name: mult_unit

Overview:
- Iterative 32x32 multiplier serving MULT/MULTU. Sits directly downstream of the instruction decoder.
- Consumes the decoder's start_mult and mult_sign strobes, plus the rs/rt operand values from the register-read stage.
- Owns the architectural HI/LO registers, which the writeback mux reads for MFHI/MFLO (out_sel).
- Exposes busy so the hazard logic stalls MFHI/MFLO and back-to-back multiplies.

Parameters:
- WIDTH, 32, operand width; the product is 2*WIDTH, split into HI and LO.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start_mult  input  1  decoder strobe: begin a multiply this cycle.
- mult_sign  input  1  1 = signed (MULT), 0 = unsigned (MULTU); sampled with start_mult.
- src_a  input  WIDTH  rs operand; sampled with start_mult.
- src_b  input  WIDTH  rt operand; sampled with start_mult.
- busy  output  1  multiply in progress; start requests are ignored while high.
- done  output  1  one-cycle pulse; HI/LO are updated and valid this cycle.
- hi  output  WIDTH  upper product word (HI register).
- lo  output  WIDTH  lower product word (LO register).

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, internal operand and accumulator registers=0. Reset mid-operation aborts the multiply; HI/LO read 0 after release.
- FSM states: IDLE, RUN, FIX.
- IDLE, on start_mult=1 at edge E0:
  - Latch sign = mult_sign & (src_a[WIDTH-1] ^ src_b[WIDTH-1]).
  - Latch the multiplicand and multiplier as magnitudes: two's-complement negate each operand if mult_sign=1 and its MSB=1; otherwise pass unchanged. 0x80000000 negates to itself, which is the correct unsigned magnitude 2^31.
  - Clear the 2*WIDTH accumulator, load counter=0, go to RUN.
- RUN: each edge performs one radix-2 shift-add step on multiplier bit 0, then increments the counter. After WIDTH steps (edges E1..E_WIDTH), go to FIX.
- FIX: at edge E_WIDTH+1:
  - {hi,lo} <= sign ? -acc : acc (2*WIDTH two's complement, wraps modulo 2^(2*WIDTH)).
  - done <= 1; state returns to IDLE.
- busy is high from the cycle after E0 through the cycle ending at E_WIDTH+1 (WIDTH+1 cycles); it is combinational from state (state != IDLE).
- Latency: start sampled at E0, result visible after E_WIDTH+1 (34 edges for WIDTH=32).
- done is high for exactly one cycle, coincident with busy=0. A new start in that same cycle is accepted.
- start_mult while busy=1 is ignored: no restart, operands not re-sampled, no error flag.
- HI/LO hold their previous values throughout RUN/FIX and change only at the FIX edge. The hazard unit must stall MFHI/MFLO while busy=1.
- mult_sign is don't-care when start_mult=0.
- src_a/src_b changes after E0 have no effect on the result.

Decomposition:
- Shared package (e.g. mips_pkg):
  - Multiplier FSM state encoding (IDLE=2'd0, RUN=2'd1, FIX=2'd2).
  - MULT_WIDTH=32.
  - Decoder func codes 6'h18/6'h19 (MULT/MULTU) and 6'h10/6'h12 (MFHI/MFLO), so the decoder and hazard unit share them.
- One natural sub-module, mult_abs: combinational conditional two's-complement negate (input value, negate enable). Instanced for both operand magnitudes and, at 2*WIDTH, for the final product. All sequencing stays in mult_unit.

Test Plan:
- Unsigned: start_mult=1, mult_sign=0, a=7, b=6 -> busy high for 33 cycles; done pulses at cycle 34; hi=0x00000000, lo=0x0000002A.
- Signed mixed: mult_sign=1, a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Same operands with mult_sign=0 -> hi=0x00000004, lo=0xFFFFFFF1.
- Extremes: MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0x00000000. MULT 0x80000000*1 -> hi=0xFFFFFFFF, lo=0x80000000.
- Ignored start: begin 3*4; at cycle 10 pulse start_mult with a=9, b=9 -> result still hi=0, lo=12; done pulses once; busy timing unchanged.
- Back-to-back: in the done cycle of 2*3 (lo=6), assert start for 5*5 -> new multiply accepted; lo=6 held for 34 cycles, then lo=25.
- Reset mid-op: start 0x1234*0x10, drop rst_n at cycle 15 -> busy=0, done=0, hi=lo=0 immediately (asynchronous). After release, no done pulse until a new start.
